// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: MMIO offsets,
// region decode and byte-lane merge.
package dmem_pkg;

  localparam logic [1:0] OFF_CYCLE   = 2'd0;
  localparam logic [1:0] OFF_SCRATCH = 2'd1;
  localparam logic [1:0] OFF_FCNT    = 2'd2;
  localparam logic [1:0] OFF_FADDR   = 2'd3;

  typedef enum logic [1:0] {HIT_RAM, HIT_MMIO, HIT_NONE} region_t;

  // Misaligned addresses never hit, whatever their upper bits say.
  function automatic region_t decode(input logic [31:0] addr,
                                     input logic [31:0] ram_bytes,
                                     input logic [27:0] mmio_page);
    region_t r;
    r = HIT_NONE;
    if (addr[1:0] == 2'b00) begin
      if (addr < ram_bytes)              r = HIT_RAM;
      else if (addr[31:4] == mmio_page)  r = HIT_MMIO;
    end
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register window: free-running cycle counter, scratch, saturating
// write-fault counter with last fault address, and the window read mux.
module dmem_mmio_regs
  import dmem_pkg::*;
#(
  parameter int unsigned FAULT_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store_en,
  input  logic        fault_en,
  input  logic [1:0]  offset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata_c,
  output logic        write_fault
);

  logic [31:0]            cycle_q;
  logic [31:0]            scratch_q;
  logic [31:0]            faddr_q;
  logic [FAULT_CNT_W-1:0] fcnt_q;

  logic wr_cycle_c;
  logic wr_scratch_c;
  logic wr_fcnt_c;

  assign wr_cycle_c   = store_en && (offset == OFF_CYCLE);
  assign wr_scratch_c = store_en && (offset == OFF_SCRATCH);
  assign wr_fcnt_c    = store_en && (offset == OFF_FCNT);

  // A counter store names the value for its own cycle, so the count carries on from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q     <= '0;
      scratch_q   <= '0;
      faddr_q     <= '0;
      fcnt_q      <= '0;
      write_fault <= 1'b0;
    end else begin
      cycle_q     <= wr_cycle_c ? (wdata + 32'd1) : (cycle_q + 32'd1);
      write_fault <= fault_en;
      if (wr_scratch_c) scratch_q <= merge_lanes(scratch_q, wdata, byte_en);
      if (wr_fcnt_c) begin
        fcnt_q  <= '0;
        faddr_q <= '0;
      end else if (fault_en) begin
        if (fcnt_q != '1) fcnt_q <= fcnt_q + FAULT_CNT_W'(1);
        faddr_q <= addr;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    unique case (offset)
      OFF_CYCLE:   rdata_c = cycle_q;
      OFF_SCRATCH: rdata_c = scratch_q;
      OFF_FCNT:    rdata_c = 32'(fcnt_q);
      OFF_FADDR:   rdata_c = faddr_q;
      default:     rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO window, zero-latency reads.
// Optional byte-lane stores are enabled by defining BYTE_WRITE_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int unsigned FAULT_CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
`ifdef BYTE_WRITE_EN
  input  logic [3:0]  byte_en,
`endif
  input  logic        write_enable,
  input  logic [31:0] WriteAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        write_fault
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [3:0]    lanes_c;
  logic [AW-1:0] widx_c;
  region_t       region_c;
  logic          store_c;
  logic [31:0]   mmio_rdata_c;

`ifdef BYTE_WRITE_EN
  assign lanes_c = byte_en;
`else
  assign lanes_c = 4'hF;
`endif

  // An empty lane mask makes the whole access a plain read, fault logic included.
  assign store_c  = write_enable && (lanes_c != 4'h0);
  assign region_c = decode(WriteAddress, RAM_BYTES, MMIO_BASE[31:4]);
  assign widx_c   = WriteAddress[AW+1:2];

  // RAM has no reset; stores are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && store_c && (region_c == HIT_RAM)) begin
      mem[widx_c] <= merge_lanes(mem[widx_c], WriteData, lanes_c);
    end
  end

  dmem_mmio_regs #(
    .FAULT_CNT_W (FAULT_CNT_W)
  ) u_mmio (
    .clk         (clk),
    .rst_n       (reset),
    .store_en    (store_c && (region_c == HIT_MMIO)),
    .fault_en    (store_c && (region_c == HIT_NONE)),
    .offset      (WriteAddress[3:2]),
    .addr        (WriteAddress),
    .wdata       (WriteData),
    .byte_en     (lanes_c),
    .rdata_c     (mmio_rdata_c),
    .write_fault (write_fault)
  );

  always_comb begin
    ReadData = '0;
    if (reset) begin
      unique case (region_c)
        HIT_RAM:  ReadData = mem[widx_c];
        HIT_MMIO: ReadData = mmio_rdata_c;
        default:  ReadData = '0;
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. It consumes the memory-stage address, write data and write enable, and returns read data in the same cycle; the memory stage pipe register captures that read data.
- Contains a word-addressed data RAM plus a small MMIO register window: cycle counter, scratch register, write-fault counter and fault address.
- Sits beside the CPU top level and replaces the bare data RAM.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; must be a power of two, minimum 4.
- MMIO_BASE, 32'h0000_1000, byte base address of the 16-byte MMIO window; must lie above the RAM region and be 16-byte aligned.
- FAULT_CNT_W, 16, width of the saturating write-fault counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_enable  input  1  store strobe from the memory stage.
- WriteAddress  input  32  byte address for both loads and stores.
- WriteData  input  32  store data.
- ReadData  output  32  combinational load data for WriteAddress.
- write_fault  output  1  registered; pulses high for one cycle after a rejected store.

Behaviour:
- Address decode:
  - RAM hit: WriteAddress < 4*DEPTH_WORDS. Word index is WriteAddress[log2(DEPTH_WORDS)+1:2].
  - MMIO hit: WriteAddress[31:4] == MMIO_BASE[31:4]. Offset is WriteAddress[3:2].
  - Misaligned: WriteAddress[1:0] != 0. This is never a hit.
- MMIO map:
  - 0x0 CYCLE_COUNT: 32 bit, RW. Increments every cycle, wrapping 0xFFFF_FFFF -> 0. A store loads WriteData and suppresses that cycle's increment; the next cycle reads WriteData+1.
  - 0x4 SCRATCH: 32 bit, RW.
  - 0x8 FAULT_COUNT: zero-extended to 32 bits. Any store clears both FAULT_COUNT and FAULT_ADDR, regardless of data.
  - 0xC FAULT_ADDR: RO, holds the address of the most recent rejected store. Stores to this offset are accepted and ignored; they are not faults.
- Reads:
  - Combinational from current state, with zero added latency.
  - A read of the location being written in the same cycle returns the old value.
  - Misaligned or unmapped addresses read as 0. Reads never fault, because the address bus carries ALU results on non-memory instructions.
- Stores:
  - Committed on the rising edge when write_enable=1 and the address is a hit.
  - A store with write_enable=1 to a misaligned or unmapped address is rejected: no state change except that FAULT_COUNT increments (saturating at all-ones), FAULT_ADDR<=WriteAddress, and write_fault=1 on the next cycle.
- Reset (reset=0, asynchronous):
  - CYCLE_COUNT, SCRATCH, FAULT_COUNT, FAULT_ADDR and write_fault are cleared to 0.
  - ReadData is forced to 0 while reset is low.
  - RAM contents are not reset. They are preserved across a mid-run reset, and are undefined at power-up.
  - On release, CYCLE_COUNT reads 0 in the first cycle and 1 in the second.
- No handshake and no stall: every access completes in the cycle it is presented.

Optional Feature:
- Macro BYTE_WRITE_EN.
- Defined:
  - Adds input byte_en[3:0]. RAM and SCRATCH stores update only the lanes where byte_en[i]=1; lane i is bits 8i+7:8i.
  - MMIO CYCLE_COUNT and FAULT_COUNT stores ignore byte_en and act as full-word.
  - A store with byte_en=0000 is a no-op and not a fault.
- Undefined: the port is absent and all stores are full-word.

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset constants OFF_CYCLE=2'd0, OFF_SCRATCH=2'd1, OFF_FCNT=2'd2, OFF_FADDR=2'd3.
  - typedef enum {HIT_RAM, HIT_MMIO, HIT_NONE} region_t.
  - A decode function.
- One sub-module, dmem_mmio_regs, holds the four registers, the counter saturation logic and the read mux. The top level keeps the RAM array and the region decode.

Test Plan:
- Store 0xDEADBEEF to 0x10, then read 0x10 the next cycle -> 0xDEADBEEF. In the same cycle as the store, ReadData shows the prior contents.
- After reset release, read MMIO_BASE+0x0 for 3 consecutive cycles -> 0, 1, 2. Store 0xFFFF_FFFE there -> the following reads are 0xFFFF_FFFF, then 0.
- Store to 0x13 (misaligned) and to 0x8000 (unmapped) -> RAM unchanged, write_fault pulses once each, FAULT_COUNT=2, FAULT_ADDR=0x8000. Store any value to MMIO_BASE+0x8 -> both read 0.
- Force FAULT_COUNT to 0xFFFE by faulting 65534 times, then fault 3 more times -> FAULT_COUNT holds 0xFFFF. Reads of unmapped addresses with write_enable=0 -> ReadData=0 and the count is unchanged.
- Write SCRATCH=0x1234_5678, assert reset mid-run for 1 cycle -> SCRATCH=0, RAM word still readable with its old value, ReadData=0 while reset is low.
- With BYTE_WRITE_EN defined: RAM word 0x0 = 0xAABBCCDD, store 0x11223344 with byte_en=0101 -> reads 0xAA22CC44. Store with byte_en=0000 -> unchanged, no fault.
